ex_unit: RTL and testbench

Parametrised execute unit for the RV32 core, successor to the single-cycle operand-mux + ALU stage. Selects operands (reg/imm/pc/constant 4), executes RV32I ALU ops in one registered cycle, and executes RV32M multiply/divide on an internal iterative engine. Uses a valid/ready handshake toward decode/issue and supports pipeline flush. Sits between ID/EX pipeline register and EX/MEM register.

---
 rtl/ex_pkg.sv | 53 +++++
 rtl/ex_muldiv_iter.sv | 120 ++++++++++++
 rtl/ex_unit.sv | 134 +++++++++++++
 tb/tb_ex_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the RV32 execute unit: op codes, operand-select modes, FSM states.
// EX_FAST_MUL_EN moves the multiplies onto a single-cycle combinational multiplier.
package ex_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [1:0] MODE_RS1_RS2 = 2'b00;
    localparam logic [1:0] MODE_RS1_IMM = 2'b01;
    localparam logic [1:0] MODE_PC_IMM  = 2'b10;
    localparam logic [1:0] MODE_PC_4    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } ex_state_e;

    // Reserved codes are not iterative: they complete as ALU ops with result 0.
    function automatic logic op_is_iter(input logic [4:0] op);
`ifdef EX_FAST_MUL_EN
        return (op >= OP_DIV) && (op <= OP_REMU);
`else
        return (op >= OP_MUL) && (op <= OP_REMU);
`endif
    endfunction

    function automatic logic op_signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M engine: one shift-add or restoring-subtract step per cycle on magnitudes,
// with sign fix-up and result select in a final cycle.
//   state   | meaning
//   ST_IDLE | waiting for start; operands latched on start
//   ST_CALC | XLEN iteration steps, counter runs XLEN-1 down to 0
//   ST_FIX  | sign correction and half/quotient/remainder select, done pulses
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    ex_state_e          state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [4:0]         op_q;
    logic [XLEN-1:0]    hi_q, lo_q, b_q;
    logic               div_q, neg_q, rneg_q, bzero_q;

    logic               sa, sb, start_div;
    logic [XLEN-1:0]    abs_a, abs_b;
    logic [XLEN:0]      mul_sum, div_rs;
    logic [XLEN-1:0]    div_diff;
    logic               div_ge;
    logic [XLEN-1:0]    hi_d, lo_d;
    logic [2*XLEN-1:0]  prod, prod_s;
    logic [XLEN-1:0]    quo, rem;

    always_comb begin
        sa        = op_signed_a(op_i) && a_i[XLEN-1];
        sb        = op_signed_b(op_i) && b_i[XLEN-1];
        abs_a     = sa ? -a_i : a_i;
        abs_b     = sb ? -b_i : b_i;
        start_div = (op_i >= OP_DIV);
    end

    // Divide compares in XLEN+1 bits; when the subtract is taken the difference fits XLEN bits.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_rs   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_rs >= {1'b0, b_q});
        div_diff = div_rs[XLEN-1:0] - b_q;
        if (div_q) begin
            hi_d = div_ge ? div_diff : div_rs[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        quo    = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
        rem    = rneg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                        result_o = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result_o = quo;
            default:                       result_o = rem;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_FIX) && !kill_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    state_q <= ST_CALC;
                    cnt_q   <= SHAMT_W'(XLEN-1);
                    op_q    <= op_i;
                    div_q   <= start_div;
                    hi_q    <= '0;
                    lo_q    <= start_div ? abs_a : abs_b;
                    b_q     <= start_div ? abs_b : abs_a;
                    neg_q   <= sa ^ sb;
                    rneg_q  <= sa;
                    bzero_q <= (b_i == '0);
                end
                ST_CALC: begin
                    if (kill_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (cnt_q == '0) state_q <= ST_FIX;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_unit.sv
// RV32 execute unit: operand select, single-cycle ALU, iterative mul/div, valid/ready with flush.
// EX_FAST_MUL_EN: multiplies complete in one cycle on a combinational 2*XLEN multiplier.
module ex_unit
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            flush_in,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] reg_1_in,
    input  logic [XLEN-1:0] reg_2_in,
    input  logic [XLEN-1:0] imm_data_in,
    input  logic [1:0]      alu_mode_select,
    input  logic [4:0]      alu_op,
    output logic            result_valid_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic            alu_zero_out,
    output logic            busy_out
);

    logic [XLEN-1:0]    op1, op2, alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, is_iter;
    logic               eng_busy, eng_done;
    logic [XLEN-1:0]    eng_res;
    logic [XLEN-1:0]    result_d, result_q;
    logic               zero_d, zero_q, valid_d, valid_q;

    always_comb begin
        op1 = reg_1_in;
        op2 = reg_2_in;
        case (alu_mode_select)
            MODE_RS1_RS2: ;
            MODE_RS1_IMM: op2 = imm_data_in;
            MODE_PC_IMM: begin
                op1 = pc_ex;
                op2 = imm_data_in;
            end
            default: begin
                op1 = pc_ex;
                op2 = XLEN'(4);
            end
        endcase
    end

    assign shamt     = op2[SHAMT_W-1:0];
    assign is_iter   = op_is_iter(alu_op);
    assign ready_out = !eng_busy && !flush_in;
    assign accept    = valid_in && ready_out;

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
    assign fm_a = {{XLEN{op_signed_a(alu_op) & op1[XLEN-1]}}, op1};
    assign fm_b = {{XLEN{op_signed_b(alu_op) & op2[XLEN-1]}}, op2};
    assign fm_p = fm_a * fm_b;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:   alu_res = op1 + op2;
            OP_SUB:   alu_res = op1 - op2;
            OP_SLL:   alu_res = op1 << shamt;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            OP_XOR:   alu_res = op1 ^ op2;
            OP_SRL:   alu_res = op1 >> shamt;
            OP_SRA:   alu_res = $signed(op1) >>> shamt;
            OP_OR:    alu_res = op1 | op2;
            OP_AND:   alu_res = op1 & op2;
            OP_PASSB: alu_res = op2;
`ifdef EX_FAST_MUL_EN
            OP_MUL:                       alu_res = fm_p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = fm_p[2*XLEN-1:XLEN];
`endif
            default:  alu_res = '0;
        endcase
    end

    ex_muldiv_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && is_iter),
        .kill_i   (flush_in),
        .op_i     (alu_op),
        .a_i      (op1),
        .b_i      (op2),
        .busy_o   (eng_busy),
        .done_o   (eng_done),
        .result_o (eng_res)
    );

    // Result and zero flag hold their value until the next completion.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (accept && !is_iter) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
        end else if (eng_done) begin
            result_d = eng_res;
            zero_d   = (eng_res == '0);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign alu_result_out   = result_q;
    assign alu_zero_out     = zero_q;
    assign result_valid_out = valid_q;
    assign busy_out         = eng_busy;

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: directed cases plus randomized ops against an arithmetic model.
module tb_ex_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] pc_ex = '0, reg_1_in = '0, reg_2_in = '0, imm_data_in = '0;
    logic [1:0]  alu_mode_select = '0;
    logic [4:0]  alu_op = '0;
    logic        ready_out, result_valid_out, alu_zero_out, busy_out;
    logic [31:0] alu_result_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .flush_in         (flush_in),
        .pc_ex            (pc_ex),
        .reg_1_in         (reg_1_in),
        .reg_2_in         (reg_2_in),
        .imm_data_in      (imm_data_in),
        .alu_mode_select  (alu_mode_select),
        .alu_op           (alu_op),
        .result_valid_out (result_valid_out),
        .alu_result_out   (alu_result_out),
        .alu_zero_out     (alu_zero_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V semantics in 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'($signed(a) >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd16: begin p = ua * ub;          return p[31:0];  end
            5'd17: begin p = sa * sb;          return p[63:32]; end
            5'd18: begin p = sa * longint'(ub); return p[63:32]; end
            5'd19: begin p = ua * ub;          return p[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            5'd23: return (b == 0) ? a : 32'(ua % ub);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op);
        if (op >= 5'd20 && op <= 5'd23) return 34;
        if (op >= 5'd16 && op <= 5'd19) begin
`ifdef EX_FAST_MUL_EN
            return 1;
`else
            return 34;
`endif
        end
        return 1;
    endfunction

    task automatic drive(input logic [1:0] mode, input logic [4:0] op, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
        alu_mode_select = mode;
        alu_op          = op;
        pc_ex           = pc;
        reg_1_in        = r1;
        reg_2_in        = r2;
        imm_data_in     = imm;
    endtask

    // One op from idle: checks latency, ready-low span, result, zero flag and pulse width.
    task automatic do_op(input string tag, input logic [1:0] mode, input logic [4:0] op,
                         input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm);
        logic [31:0] a, b, exp;
        int lat, el, rlow;
        a   = mode[1] ? pc : r1;
        b   = (mode == 2'b00) ? r2 : ((mode == 2'b11) ? 32'd4 : imm);
        exp = model(op, a, b);
        el  = exp_lat(op);
        @(negedge clk);
        drive(mode, op, pc, r1, r2, imm);
        valid_in = 1'b1;
        check_eq({tag, ".rdy"}, {31'b0, ready_out}, 32'd1);
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat  = 1;
        rlow = 0;
        while (!result_valid_out && lat < 100) begin
            if (!ready_out) rlow++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".lat"},  32'(lat), 32'(el));
        check_eq({tag, ".rlow"}, 32'(rlow), 32'(el - 1));
        check_eq({tag, ".res"},  alu_result_out, exp);
        check_eq({tag, ".zero"}, {31'b0, alu_zero_out}, {31'b0, (exp == 32'd0)});
        check_eq({tag, ".rdyv"}, {31'b0, ready_out}, 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, ".pulse"}, {31'b0, result_valid_out}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int seen;
        logic [4:0] rop;
        logic [1:0] rmode;

        #12;
        check_eq("rst.res",   alu_result_out, 32'd0);
        check_eq("rst.zero",  {31'b0, alu_zero_out}, 32'd1);
        check_eq("rst.valid", {31'b0, result_valid_out}, 32'd0);
        check_eq("rst.busy",  {31'b0, busy_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rst.ready", {31'b0, ready_out}, 32'd1);

        // Back-to-back ALU accepts
        @(negedge clk);
        drive(2'b01, 5'd0, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD);
        valid_in = 1'b1;
        @(posedge clk);
        #1 drive(2'b00, 5'd1, 32'd0, 32'd5, 32'd5, 32'd0);
        check_eq("b2b.v1",   {31'b0, result_valid_out}, 32'd1);
        check_eq("b2b.r1",   alu_result_out, 32'd2);
        check_eq("b2b.z1",   {31'b0, alu_zero_out}, 32'd0);
        @(posedge clk);
        #1 valid_in = 1'b0;
        check_eq("b2b.v2",   {31'b0, result_valid_out}, 32'd1);
        check_eq("b2b.r2",   alu_result_out, 32'd0);
        check_eq("b2b.z2",   {31'b0, alu_zero_out}, 32'd1);
        @(posedge clk);
        #1 check_eq("b2b.v3", {31'b0, result_valid_out}, 32'd0);

        do_op("pc4",    2'b11, 5'd0,  32'h100, 32'd0, 32'd0, 32'd0);
        do_op("sra",    2'b00, 5'd7,  32'd0, 32'h8000_0000, 32'h21, 32'd0);
        do_op("mulh",   2'b00, 5'd17, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0);
        do_op("mulhsu", 2'b00, 5'd18, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("div",    2'b00, 5'd20, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
        do_op("rem",    2'b00, 5'd22, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
        do_op("divu0",  2'b00, 5'd21, 32'd0, 32'd9, 32'd0, 32'd0);
        do_op("remu0",  2'b00, 5'd23, 32'd0, 32'd9, 32'd0, 32'd0);
        do_op("divov",  2'b00, 5'd20, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("remov",  2'b00, 5'd22, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("div0s",  2'b00, 5'd20, 32'd0, 32'hFFFF_FFF0, 32'd0, 32'd0);
        do_op("rsvd",   2'b00, 5'd13, 32'd0, 32'd3, 32'd4, 32'd0);

        // Flush during CALC cycle 10 of a DIVU
        do_op("pre",    2'b00, 5'd0,  32'd0, 32'd3, 32'd4, 32'd0);
        @(negedge clk);
        drive(2'b00, 5'd21, 32'd0, 32'd100, 32'd7, 32'd0);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_in = 1'b1;
        #1 check_eq("fl.rdy0", {31'b0, ready_out}, 32'd0);
        @(posedge clk);
        #1 flush_in = 1'b0;
        #1;
        check_eq("fl.rdy1", {31'b0, ready_out}, 32'd1);
        check_eq("fl.busy", {31'b0, busy_out}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (result_valid_out) seen++;
        end
        check_eq("fl.nopulse", 32'(seen), 32'd0);
        check_eq("fl.res",     alu_result_out, 32'd7);
        check_eq("fl.zero",    {31'b0, alu_zero_out}, 32'd0);
        do_op("post",   2'b00, 5'd0,  32'd0, 32'd1, 32'd1, 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        drive(2'b00, 5'd16, 32'd0, 32'd3, 32'd5, 32'd0);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mr.res",   alu_result_out, 32'd0);
        check_eq("mr.zero",  {31'b0, alu_zero_out}, 32'd1);
        check_eq("mr.valid", {31'b0, result_valid_out}, 32'd0);
        check_eq("mr.busy",  {31'b0, busy_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("mr.add", 2'b00, 5'd0,  32'd0, 32'd1, 32'd1, 32'd0);

        for (int i = 0; i < 80; i++) begin
            rop   = 5'($urandom_range(0, 31));
            rmode = 2'($urandom_range(0, 3));
            do_op($sformatf("rnd%0d.op%0d", i, rop), rmode, rop, rnd_val(), rnd_val(), rnd_val(), rnd_val());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
